// File: rtl/airlock_pkg.sv
// Shared airlock definitions: sequencer states, direction codes and the
// door/pressure/request signal levels shared by the sequencer and the pressurizer.
package airlock_pkg;

    typedef enum logic [3:0] {
        IDLE,
        EQ_REQ,
        EQ_WAIT,
        OPEN_1,
        CLOSE_1,
        XF_REQ,
        XF_WAIT,
        OPEN_2,
        CLOSE_2,
        FAULT
    } airlock_state_e;

    localparam logic DIR_ENTER   = 1'b0;
    localparam logic DIR_EXIT    = 1'b1;
    localparam logic OPEN        = 1'b1;
    localparam logic PRESSURIZED = 1'b1;
    localparam logic REQ_ACTIVE  = 1'b0;

    // Outside is vacuum and inside is pressurized, so equalize to the side opened first.
    function automatic logic equalize_target(input logic dir);
        return (dir == DIR_EXIT) ? PRESSURIZED : ~PRESSURIZED;
    endfunction

    function automatic logic transfer_target(input logic dir);
        return ~equalize_target(dir);
    endfunction

    function automatic logic is_timed(input airlock_state_e state);
        return (state != IDLE) && (state != FAULT);
    endfunction

    function automatic logic is_hold(input airlock_state_e state);
        return (state == OPEN_1) || (state == OPEN_2);
    endfunction

endpackage

// File: rtl/airlock_timer.sv
// Clearable, saturating cycle counter shared by all timed sequencer states.
module airlock_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             atLimit
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q < limit)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // High in the last cycle before the count lands on the limit, so a transition
    // decided on it takes effect exactly `limit` cycles after the state was entered.
    assign atLimit = ({1'b0, count_q} + (WIDTH + 1)'(1)) >= {1'b0, limit};

endmodule

// File: rtl/airlock_sequencer.sv
// Airlock master sequencer: equalize, first door, pressure transfer, second door,
// with a sticky fault on any pressure change or door that fails to complete in time.
module airlock_sequencer
    import airlock_pkg::*;
#(
    parameter int TIMEOUT   = 15,
    parameter int DOOR_HOLD = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enterReq,
    input  logic exitReq,
    input  logic pressurized,
    input  logic innerDoorState,
    input  logic outerDoorState,
    output logic pressurizeSignal,
    output logic depressurizeSignal,
    output logic openInner,
    output logic openOuter,
    output logic busy,
    output logic fault
);

    localparam int CNT_MAX = (TIMEOUT > DOOR_HOLD) ? TIMEOUT : DOOR_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] HOLD_CNT    = CNT_W'(DOOR_HOLD);

    airlock_state_e state_q, state_d;
    logic dir_q, dir_d;
    logic press_n_q, press_n_d;
    logic depress_n_q, depress_n_d;
    logic open_inner_q, open_inner_d;
    logic open_outer_q, open_outer_d;
    logic busy_q, busy_d;
    logic fault_q, fault_d;

    logic             timer_clear;
    logic             timer_enable;
    logic [CNT_W-1:0] timer_limit;
    logic             at_limit;

    logic eq_target;
    logic xf_target;
    logic req_target;
    logic pulse_active;
    logic doors_closed;
    logic first_door_open;
    logic second_door_open;

    assign eq_target        = equalize_target(dir_q);
    assign xf_target        = transfer_target(dir_q);
    assign req_target       = (state_q == XF_REQ) ? xf_target : eq_target;
    assign pulse_active     = (press_n_q == REQ_ACTIVE) || (depress_n_q == REQ_ACTIVE);
    assign doors_closed     = (innerDoorState != OPEN) && (outerDoorState != OPEN);
    assign first_door_open  = (dir_q == DIR_ENTER) ? (outerDoorState == OPEN) : (innerDoorState == OPEN);
    assign second_door_open = (dir_q == DIR_ENTER) ? (innerDoorState == OPEN) : (outerDoorState == OPEN);

    assign timer_clear  = (state_d != state_q);
    assign timer_enable = is_timed(state_q);
    assign timer_limit  = is_hold(state_q) ? HOLD_CNT : TIMEOUT_CNT;

    airlock_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .limit   (timer_limit),
        .atLimit (at_limit)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            dir_q        <= DIR_ENTER;
            press_n_q    <= ~REQ_ACTIVE;
            depress_n_q  <= ~REQ_ACTIVE;
            open_inner_q <= ~OPEN;
            open_outer_q <= ~OPEN;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            press_n_q    <= press_n_d;
            depress_n_q  <= depress_n_d;
            open_inner_q <= open_inner_d;
            open_outer_q <= open_outer_d;
            busy_q       <= busy_d;
            fault_q      <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        unique case (state_q)
            IDLE: begin
                if (enterReq == REQ_ACTIVE) begin
                    dir_d   = DIR_ENTER;
                    state_d = EQ_REQ;
                end else if (exitReq == REQ_ACTIVE) begin
                    dir_d   = DIR_EXIT;
                    state_d = EQ_REQ;
                end
            end
            EQ_REQ: begin
                if (pulse_active)                  state_d = EQ_WAIT;
                else if (pressurized == eq_target) state_d = OPEN_1;
                else if (at_limit)                 state_d = FAULT;
            end
            EQ_WAIT: begin
                if (pressurized == eq_target) state_d = OPEN_1;
                else if (at_limit)            state_d = FAULT;
            end
            OPEN_1: begin
                if (at_limit) state_d = CLOSE_1;
            end
            CLOSE_1: begin
                if (!first_door_open) state_d = XF_REQ;
                else if (at_limit)    state_d = FAULT;
            end
            XF_REQ: begin
                if (pulse_active)  state_d = XF_WAIT;
                else if (at_limit) state_d = FAULT;
            end
            XF_WAIT: begin
                if (pressurized == xf_target) state_d = OPEN_2;
                else if (at_limit)            state_d = FAULT;
            end
            OPEN_2: begin
                if (at_limit) state_d = CLOSE_2;
            end
            CLOSE_2: begin
                if (!second_door_open) state_d = IDLE;
                else if (at_limit)     state_d = FAULT;
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A request pulse fires only while a REQ state is holding, so skips, timeouts
    // and the cycle that ends an already-issued pulse never produce a second one.
    always_comb begin
        press_n_d    = ~REQ_ACTIVE;
        depress_n_d  = ~REQ_ACTIVE;
        open_inner_d = ~OPEN;
        open_outer_d = ~OPEN;
        busy_d       = (state_d != IDLE);
        fault_d      = (state_d == FAULT);
        if (((state_q == EQ_REQ) || (state_q == XF_REQ)) && (state_d == state_q)
            && !pulse_active && doors_closed) begin
            if (req_target == PRESSURIZED) press_n_d   = REQ_ACTIVE;
            else                           depress_n_d = REQ_ACTIVE;
        end
        if (state_d == OPEN_1) begin
            if (dir_q == DIR_ENTER) open_outer_d = OPEN;
            else                    open_inner_d = OPEN;
        end else if (state_d == OPEN_2) begin
            if (dir_q == DIR_ENTER) open_inner_d = OPEN;
            else                    open_outer_d = OPEN;
        end
    end

    assign pressurizeSignal   = press_n_q;
    assign depressurizeSignal = depress_n_q;
    assign openInner          = open_inner_q;
    assign openOuter          = open_outer_q;
    assign busy               = busy_q;
    assign fault              = fault_q;

endmodule

// File: tb/tb_airlock_sequencer.sv
// Closed-loop bench for airlock_sequencer: behavioural pressurizer and doors,
// with every cycle compared against a timeline predicted from the sequence rules.
module tb_airlock_sequencer;

    localparam int TB_TIMEOUT        = 15;
    localparam int TB_HOLD           = 4;
    localparam int MODE_NORMAL       = 0;
    localparam int MODE_STUCK        = 1;
    localparam int MODE_DISCONNECTED = 2;
    localparam logic [5:0] RESET_VEC = 6'b001100;

    logic clk            = 1'b0;
    logic reset          = 1'b0;
    logic enterReq       = 1'b1;
    logic exitReq        = 1'b1;
    logic pressurized    = 1'b0;
    logic innerDoorState = 1'b0;
    logic outerDoorState = 1'b0;
    logic pressurizeSignal;
    logic depressurizeSignal;
    logic openInner;
    logic openOuter;
    logic busy;
    logic fault;

    logic stuckInner = 1'b0;
    logic plantTie   = 1'b0;
    logic plantSet   = 1'b0;
    logic plantVal   = 1'b0;
    logic pendTgt    = 1'b0;
    int   pendCnt    = 0;
    int   plantDelay = 7;

    int   compCount = 0;
    int   failCount = 0;
    int   txnIdx    = 0;
    logic pressNow  = 1'b0;

    typedef struct {
        logic dirExit;
        logic eqTarget;
        logic xfTarget;
        int   eqPulseK;
        int   xfPulseK;
        int   open1K;
        int   open2K;
        int   endK;
        int   faultK;
    } plan_t;

    always #5 clk = ~clk;

    airlock_sequencer #(
        .TIMEOUT   (TB_TIMEOUT),
        .DOOR_HOLD (TB_HOLD)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .enterReq           (enterReq),
        .exitReq            (exitReq),
        .pressurized        (pressurized),
        .innerDoorState     (innerDoorState),
        .outerDoorState     (outerDoorState),
        .pressurizeSignal   (pressurizeSignal),
        .depressurizeSignal (depressurizeSignal),
        .openInner          (openInner),
        .openOuter          (openOuter),
        .busy               (busy),
        .fault              (fault)
    );

    // Doors follow their command one cycle late; stuckInner jams the inner door open.
    always @(posedge clk) begin
        outerDoorState <= openOuter;
        innerDoorState <= openInner | stuckInner;
    end

    // Pressurizer: a sampled request changes the chamber plantDelay edges later.
    always @(posedge clk) begin
        if (plantTie) begin
            pressurized <= 1'b0;
            pendCnt     <= 0;
        end else if (plantSet) begin
            pressurized <= plantVal;
            pendCnt     <= 0;
        end else if (pendCnt != 0) begin
            if (pendCnt == 1) pressurized <= pendTgt;
            pendCnt <= pendCnt - 1;
        end else if (!pressurizeSignal) begin
            pendTgt <= 1'b1;
            pendCnt <= plantDelay;
        end else if (!depressurizeSignal) begin
            pendTgt <= 1'b0;
            pendCnt <= plantDelay;
        end
    end

    function automatic plan_t planTxn(input logic dirExit, input logic pressStart,
                                      input int d, input int mode);
        plan_t p;
        p.dirExit  = dirExit;
        p.eqTarget = dirExit ? 1'b1 : 1'b0;
        p.xfTarget = ~p.eqTarget;
        p.faultK   = -1;
        if (pressStart == p.eqTarget) begin
            p.eqPulseK = -1;
            p.open1K   = 2;
        end else begin
            p.eqPulseK = 2;
            p.open1K   = 4 + d;
        end
        p.xfPulseK = p.open1K + TB_HOLD + 3;
        p.open2K   = p.xfPulseK + 2 + d;
        p.endK     = p.open2K + TB_HOLD + 2;
        if (mode == MODE_STUCK) begin
            p.faultK = p.open2K + TB_HOLD + TB_TIMEOUT;
        end else if (mode == MODE_DISCONNECTED) begin
            p.faultK   = p.eqPulseK + 1 + TB_TIMEOUT;
            p.xfPulseK = 1000;
            p.open1K   = 1000;
            p.open2K   = 1000;
        end
        return p;
    endfunction

    // Expected {busy, fault, pressurizeSignal, depressurizeSignal, openInner, openOuter} in cycle k.
    function automatic logic [5:0] expVec(input plan_t p, input int k);
        logic b, f, pn, dn, oi, oo;
        b  = (k >= 1) && ((p.faultK >= 0) || (k < p.endK));
        f  = (p.faultK >= 0) && (k >= p.faultK);
        pn = 1'b1;
        dn = 1'b1;
        oi = 1'b0;
        oo = 1'b0;
        if (!f) begin
            if (k == p.eqPulseK) begin
                if (p.eqTarget) pn = 1'b0;
                else            dn = 1'b0;
            end
            if (k == p.xfPulseK) begin
                if (p.xfTarget) pn = 1'b0;
                else            dn = 1'b0;
            end
            if (k >= p.open1K && k < p.open1K + TB_HOLD) begin
                if (p.dirExit) oi = 1'b1;
                else           oo = 1'b1;
            end
            if (k >= p.open2K && k < p.open2K + TB_HOLD) begin
                if (p.dirExit) oo = 1'b1;
                else           oi = 1'b1;
            end
        end
        return {b, f, pn, dn, oi, oo};
    endfunction

    function automatic logic [5:0] observed();
        return {busy, fault, pressurizeSignal, depressurizeSignal, openInner, openOuter};
    endfunction

    task automatic checkOutput(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        compCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: observed %b required %b (busy,fault,pressN,depressN,openIn,openOut)",
                     tag, obs, exp);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic setChamber(input logic v);
        plantSet = 1'b1;
        plantVal = v;
        @(negedge clk);
        plantSet = 1'b0;
        pressNow = v;
    endtask

    task automatic resetAndCheck(input string tag);
        reset = 1'b0;
        @(negedge clk);
        checkOutput(tag, observed(), RESET_VEC);
        reset = 1'b1;
    endtask

    // One request from IDLE, checked every cycle until it completes or faults.
    task automatic applyStimulus(input logic enterLow, input logic exitLow,
                                 input int mode, input bit chatter);
        plan_t p;
        int lastK;
        txnIdx++;
        plantDelay = 7 + int'($urandom_range(0, 1));
        p = planTxn(enterLow ? 1'b0 : 1'b1, pressNow, plantDelay, mode);
        lastK = (p.faultK >= 0) ? p.faultK + 4 : p.endK;
        enterReq = ~enterLow;
        exitReq  = ~exitLow;
        @(posedge clk);
        for (int k = 1; k <= lastK; k++) begin
            @(negedge clk);
            checkOutput($sformatf("txn%0d k%0d", txnIdx, k), observed(), expVec(p, k));
            if (mode == MODE_STUCK && k == p.open2K + 1) stuckInner = 1'b1;
            if (chatter && (k + 1 < lastK) && ($urandom_range(0, 3) == 0)) begin
                enterReq = ($urandom_range(0, 1) == 0);
                exitReq  = ($urandom_range(0, 1) == 0);
            end else begin
                enterReq = 1'b1;
                exitReq  = 1'b1;
            end
        end
        if (mode == MODE_DISCONNECTED) pressNow = 1'b0;
        else                           pressNow = p.xfTarget;
    endtask

    initial begin
        plan_t rp;
        int kind;
        @(negedge clk);
        plantSet = 1'b1;
        plantVal = 1'b1;
        idleCycles(3);
        plantSet = 1'b0;
        pressNow = 1'b1;
        checkOutput("reset", observed(), RESET_VEC);
        reset = 1'b1;
        idleCycles(2);
        checkOutput("idle after reset", observed(), RESET_VEC);

        applyStimulus(1'b1, 1'b0, MODE_NORMAL, 1'b0);
        idleCycles(2);
        applyStimulus(1'b0, 1'b1, MODE_NORMAL, 1'b0);
        idleCycles(1);
        applyStimulus(1'b1, 1'b1, MODE_NORMAL, 1'b1);
        idleCycles(2);

        applyStimulus(1'b1, 1'b0, MODE_STUCK, 1'b1);
        stuckInner = 1'b0;
        resetAndCheck("stuck door reset");
        idleCycles(3);

        plantTie = 1'b1;
        idleCycles(2);
        pressNow = 1'b0;
        applyStimulus(1'b0, 1'b1, MODE_DISCONNECTED, 1'b0);
        plantTie = 1'b0;
        resetAndCheck("disconnected reset");
        idleCycles(2);

        setChamber(1'b0);
        idleCycles(1);
        rp = planTxn(1'b0, pressNow, plantDelay, MODE_NORMAL);
        enterReq = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            enterReq = 1'b1;
            checkOutput($sformatf("open1 reset k%0d", k), observed(), expVec(rp, k));
        end
        resetAndCheck("reset mid open1");
        idleCycles(3);
        applyStimulus(1'b1, 1'b0, MODE_NORMAL, 1'b0);

        for (int i = 0; i < 20; i++) begin
            idleCycles(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) setChamber($urandom_range(0, 1) == 1);
            kind = int'($urandom_range(0, 2));
            applyStimulus(kind != 1, kind != 0, MODE_NORMAL, 1'b1);
        end
        idleCycles(2);
        checkOutput("final idle", observed(), RESET_VEC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: run still active, required finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
